// File: rtl/alu_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_arbiter_pkg
//   Shared definitions for the ALU arbiter slice:
//     - data / opcode widths
//     - ALU funct codes (FN_ADD .. FN_SRA)
//     - arbiter FSM state encoding
//     - is_valid_funct(): opcode screen applied before anything reaches the ALU
// -----------------------------------------------------------------------------
package alu_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 6;

  localparam logic [OP_W-1:0] FN_ADD  = 6'b100000;
  localparam logic [OP_W-1:0] FN_ADDU = 6'b100001;
  localparam logic [OP_W-1:0] FN_SUB  = 6'b100010;
  localparam logic [OP_W-1:0] FN_SUBU = 6'b100011;
  localparam logic [OP_W-1:0] FN_AND  = 6'b100100;
  localparam logic [OP_W-1:0] FN_OR   = 6'b100101;
  localparam logic [OP_W-1:0] FN_XOR  = 6'b100110;
  localparam logic [OP_W-1:0] FN_NOR  = 6'b100111;
  localparam logic [OP_W-1:0] FN_SLT  = 6'b101010;
  localparam logic [OP_W-1:0] FN_SLTU = 6'b101011;
  localparam logic [OP_W-1:0] FN_SLL  = 6'b000000;
  localparam logic [OP_W-1:0] FN_SRL  = 6'b000010;
  localparam logic [OP_W-1:0] FN_SRA  = 6'b000011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  function automatic logic is_valid_funct(input logic [OP_W-1:0] fn);
    case (fn)
      FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
      FN_AND, FN_OR, FN_XOR, FN_NOR,
      FN_SLT, FN_SLTU,
      FN_SLL, FN_SRL, FN_SRA: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
//   Request and response channels of the ALU arbiter.
//     req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//     req_op/req_a/req_b  : packed per-requester payload, slice i = requester i
//     rsp_*               : single response channel tagged with rsp_id
//   modport master : requesters + response consumer
//   modport slave  : the arbiter
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
);
  import alu_arbiter_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [OP_W*NUM_REQ-1:0]   req_op;
  logic [DATA_W*NUM_REQ-1:0] req_a;
  logic [DATA_W*NUM_REQ-1:0] req_b;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_result;
  logic                      rsp_carry;
  logic                      rsp_zero;
  logic                      rsp_sign;
  logic                      rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result,
           rsp_carry, rsp_zero, rsp_sign, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result,
           rsp_carry, rsp_zero, rsp_sign, rsp_err
  );

endinterface

// File: rtl/alu_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// alu_arbiter_rr_picker
//   Combinational round-robin priority select.
//     req_valid  : per-requester valid
//     last_grant : index of the most recently granted requester
//     gnt        : one-hot grant (zero when nobody is valid)
//     gnt_idx    : index of the granted requester (0 when nobody is valid)
//   Search starts at last_grant+1 and wraps modulo NUM_REQ.
// -----------------------------------------------------------------------------
module alu_arbiter_rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx
);

  logic [ID_W:0] cand;
  logic          found;

  // One extra bit on cand holds last_grant+off+1 before the modulo; a single
  // conditional subtract suffices since the sum never reaches 2*NUM_REQ.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = {1'b0, last_grant} + (ID_W+1)'(off + 1);
      if (cand >= (ID_W+1)'(NUM_REQ))
        cand = cand - (ID_W+1)'(NUM_REQ);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] && (cand == (ID_W+1)'(i))) begin
          gnt[i]  = 1'b1;
          gnt_idx = ID_W'(i);
          found   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational ALU between NUM_REQ requesters.
//   One operation per grant: IDLE (arbitrate + accept) -> ISSUE (ALU driven
//   from registers) -> RESP (hold response until consumed) -> IDLE.
//   Unsupported funct codes skip ISSUE and are answered with rsp_err=1.
//   Ports:
//     clk, rst_n              : clock, asynchronous active-low reset
//     bus (slave)             : request / response channels
//     alu_operation/A/B       : registered ALU drive, held while idle
//     alu_result/carry/zero/sign : ALU outputs, captured at the end of ISSUE
//     busy                    : high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_arbiter_if.slave      bus,
  output logic [OP_W-1:0]   alu_operation,
  output logic [DATA_W-1:0] alu_operandA,
  output logic [DATA_W-1:0] alu_operandB,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero,
  input  logic              alu_sign,
  output logic              busy
);

  state_t              state;
  logic [ID_W-1:0]     last_grant;
  logic [ID_W-1:0]     cur_id;

  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_idx;
  logic                any_gnt;

  logic [OP_W-1:0]     op_arr [NUM_REQ];
  logic [DATA_W-1:0]   a_arr  [NUM_REQ];
  logic [DATA_W-1:0]   b_arr  [NUM_REQ];
  logic [OP_W-1:0]     sel_op;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;

  // Issue-stage registers (drive the shared ALU)
  logic [OP_W-1:0]     alu_op_p0;
  logic [DATA_W-1:0]   opa_p0;
  logic [DATA_W-1:0]   opb_p0;

  // Response-stage registers
  logic                vld_p1;
  logic [ID_W-1:0]     rsp_id_p1;
  logic [DATA_W-1:0]   result_p1;
  logic                carry_p1;
  logic                zero_p1;
  logic                sign_p1;
  logic                err_p1;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_arr[g] = bus.req_op[OP_W*g +: OP_W];
    assign a_arr[g]  = bus.req_a[DATA_W*g +: DATA_W];
    assign b_arr[g]  = bus.req_b[DATA_W*g +: DATA_W];
  end

  alu_arbiter_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req_valid  (bus.req_valid),
    .last_grant (last_grant),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  assign any_gnt = |gnt;
  assign sel_op  = op_arr[gnt_idx];
  assign sel_a   = a_arr[gnt_idx];
  assign sel_b   = b_arr[gnt_idx];

  // The handshake is combinational in IDLE; rst_n gates it so nothing looks
  // accepted while reset is held.
  assign bus.req_ready = (rst_n && (state == IDLE)) ? gnt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      cur_id     <= '0;
      alu_op_p0  <= '0;
      opa_p0     <= '0;
      opb_p0     <= '0;
      vld_p1     <= 1'b0;
      rsp_id_p1  <= '0;
      result_p1  <= '0;
      carry_p1   <= 1'b0;
      zero_p1    <= 1'b0;
      sign_p1    <= 1'b0;
      err_p1     <= 1'b0;
    end else begin
      case (state)
        // Arbitrate and accept into the issue stage (_p0)
        IDLE: begin
          if (any_gnt) begin
            last_grant <= gnt_idx;
            cur_id     <= gnt_idx;
            if (is_valid_funct(sel_op)) begin
              alu_op_p0 <= sel_op;
              opa_p0    <= sel_a;
              opb_p0    <= sel_b;
              state     <= ISSUE;
            end else begin
              // Bad opcode: answer straight away, ALU drive left untouched.
              rsp_id_p1 <= gnt_idx;
              result_p1 <= '0;
              carry_p1  <= 1'b0;
              zero_p1   <= 1'b0;
              sign_p1   <= 1'b0;
              err_p1    <= 1'b1;
              vld_p1    <= 1'b1;
              state     <= RESP;
            end
          end
        end
        // Issue stage (_p0) -> response stage (_p1): capture ALU outputs
        ISSUE: begin
          rsp_id_p1 <= cur_id;
          result_p1 <= alu_result;
          carry_p1  <= alu_carry;
          zero_p1   <= alu_zero;
          sign_p1   <= alu_sign;
          err_p1    <= 1'b0;
          vld_p1    <= 1'b1;
          state     <= RESP;
        end
        // Response stage (_p1): hold until the consumer takes it
        RESP: begin
          if (bus.rsp_ready) begin
            vld_p1 <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          vld_p1 <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign alu_operation  = alu_op_p0;
  assign alu_operandA   = opa_p0;
  assign alu_operandB   = opb_p0;

  assign bus.rsp_valid  = vld_p1;
  assign bus.rsp_id     = rsp_id_p1;
  assign bus.rsp_result = result_p1;
  assign bus.rsp_carry  = carry_p1;
  assign bus.rsp_zero   = zero_p1;
  assign bus.rsp_sign   = sign_p1;
  assign bus.rsp_err    = err_p1;

  assign busy = (state != IDLE);

endmodule
